// File: rtl/tt_sum_splitter_if.sv
// Handshake/bus bundle for tt_sum_splitter: upstream pair input, downstream
// result output, and the self-check status outputs.
interface tt_sum_splitter_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         sum_in;
    logic [WIDTH-1:0]         opb_in;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         a_out;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   level;
    logic [WIDTH-1:0]         checksum;
    logic [15:0]              xfer_count;
    logic                     clear;

    // Driver side (upstream producer + downstream consumer + control)
    modport master (
        output sum_in, opb_in, in_valid, out_ready, clear,
        input  in_ready, a_out, out_valid, level, checksum, xfer_count
    );

    // Block side
    modport slave (
        input  sum_in, opb_in, in_valid, out_ready, clear,
        output in_ready, a_out, out_valid, level, checksum, xfer_count
    );
endinterface

// File: rtl/tt_sum_splitter.sv
// Recovers operand A = sum - B (mod 2^WIDTH) from an adder's output stream,
// buffers results in a small FIFO, and keeps an XOR checksum and pop counter
// of everything delivered downstream.
module tt_sum_splitter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    tt_sum_splitter_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]               level_q, level_d;
    logic [WIDTH-1:0]            a_out_q, a_out_d;
    logic [WIDTH-1:0]            checksum_q, checksum_d;
    logic [15:0]                 xfer_q, xfer_d;

    logic full, empty, in_ready, out_valid, push, pop;

    // Handshake flags come only from registered occupancy; in_ready never
    // looks at out_ready, so a full FIFO refuses input even while popping.
    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign in_ready  = !full && !rst;
    assign out_valid = !empty;
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.a_out      = a_out_q;
    assign bus.level      = level_q;
    assign bus.checksum   = checksum_q;
    assign bus.xfer_count = xfer_q;

    // Next-state: FIFO write/read, occupancy, head register, checksum/counter
    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        a_out_d    = a_out_q;
        checksum_d = checksum_q;
        xfer_d     = xfer_q;

        // Subtract at write time; only the recovered A is stored.
        if (push) begin
            mem_d[wr_ptr_q] = bus.sum_in - bus.opb_in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Head is pre-registered from the post-edge FIFO image, giving the
        // one-cycle push-to-output latency even into an empty FIFO. When the
        // FIFO drains, the last delivered value is held.
        if (level_d != '0) begin
            a_out_d = mem_d[rd_ptr_d];
        end

        // clear beats a same-cycle pop for the statistics only.
        if (bus.clear) begin
            checksum_d = '0;
            xfer_d     = '0;
        end else if (pop) begin
            checksum_d = checksum_q ^ a_out_q;
            xfer_d     = xfer_q + 16'd1;
        end
    end

    // State registers; reset discards all entries asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            a_out_q    <= '0;
            checksum_q <= '0;
            xfer_q     <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            a_out_q    <= a_out_d;
            checksum_q <= checksum_d;
            xfer_q     <= xfer_d;
        end
    end
endmodule

// File: doc/tt_sum_splitter.md
Name: tt_sum_splitter

Overview:
- Inverse of the pin-level adder used in our TinyTapeout tiles. Takes a stream of (sum, operand B) pairs and recovers operand A = sum − B mod 2^WIDTH.
- A small FIFO with valid/ready handshakes on both sides buffers the recovered values.
- Also keeps a running XOR checksum and a transfer counter, so a tile can self-check the adder datapath from the far end of the pins.

Parameters:
- WIDTH, 8, datapath width of sum, operand and result.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- sum_in  input  WIDTH  sum word from upstream.
- opb_in  input  WIDTH  known operand B paired with sum_in.
- in_valid  input  1  upstream offers a pair.
- in_ready  output  1  block can accept a pair this cycle.
- a_out  output  WIDTH  recovered operand A at FIFO head.
- out_valid  output  1  a_out holds a valid entry.
- out_ready  input  1  downstream accepts a_out this cycle.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- checksum  output  WIDTH  XOR of every a_out popped since reset/clear.
- xfer_count  output  16  number of pops since reset/clear.
- clear  input  1  synchronous clear of checksum and xfer_count.

Behaviour:
- Reset (rst=1, asynchronous): FIFO empty, read/write pointers 0, level=0, checksum=0, xfer_count=0, out_valid=0, a_out=0. in_ready is forced 0 while rst is high.
- Push: occurs when in_valid && in_ready at a rising edge. The stored value is (sum_in − opb_in) mod 2^WIDTH; no carry or borrow is kept. The subtract happens at write time; the FIFO stores only the result.
- Pop: occurs when out_valid && out_ready at a rising edge. The head advances and a_out shows the next entry. a_out and out_valid are driven from registered FIFO state; there is no combinational path from in_* to out_*.
- Latency: an accepted pair appears on a_out with out_valid=1 in the cycle after the accepting edge (1 cycle), including when the FIFO was empty.
- in_ready = (level != DEPTH) && !rst. When full, in_ready=0 even if a pop occurs that cycle; there is no pass-through or bypass. This keeps in_ready free of out_ready.
- out_valid = (level != 0). When out_valid=0, a_out holds its last value (0 after reset).
- Simultaneous push and pop with 0 < level < DEPTH: both happen, level unchanged.
- Empty with push only: level 0→1. Full with pop only: level DEPTH→DEPTH−1.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH inclusive.
- Handshake rules, upstream: sum_in, opb_in and in_valid are stable only while in_valid is high. The block samples them only on a push edge. in_valid may drop without a transfer.
- Handshake rules, downstream: a_out and out_valid stay stable until popped. out_ready may toggle freely.
- Checksum and counter: on each pop, checksum ^= popped a_out and xfer_count += 1. xfer_count wraps 16'hFFFF→0.
- clear=1 at an edge: checksum and xfer_count become 0, and clear wins over a same-cycle pop. That pop is not counted or XORed, but the FIFO pop still occurs. clear does not touch FIFO contents, level or handshakes.
- Reset mid-operation: all entries are discarded immediately and asynchronously, out_valid drops without an edge, and no partial pop is counted.

Test Plan:
- Reset, then push sum=8'h30, B=8'h10, out_ready=0 → next cycle out_valid=1, a_out=8'h20, level=1; in_ready stays 1.
- Push sum=8'h05, B=8'h0A (wrap) → a_out=8'hFB. Pop it → checksum=8'hFB, xfer_count=1.
- Fill 4 pairs with out_ready=0 → level=4, in_ready=0. Drive in_valid=1 and out_ready=1 together → pop only, level=3, in_ready=1 next cycle. Pops are in FIFO order.
- Continuous in_valid=1 and out_ready=1 streaming 20 pairs (A=i, B=3i) → level stays ≤1 after the first cycle, all 20 A values correct in order, xfer_count=20, checksum = XOR of 0..19 = 8'h00.
- With 2 entries queued, assert clear and out_ready in the same cycle → checksum=0, xfer_count=0, level=1. The next pop updates both normally.
- Assert rst asynchronously mid-stream with level=3 → out_valid=0, level=0, in_ready=0 immediately. After release: in_ready=1, checksum=0, xfer_count=0.
